ldm_stm_sequencer: RTL and testbench

Register-list sequencer for block transfers (LDM/STM) in the ARMv4 core. Latches the 16-bit register list and base address when microcode starts a block transfer. Then presents one register index and one transfer address per memory step, and raises `done` after the last transfer; this is the `RM_CNTR_DONE` source for the control-store sequencer. It also computes the base write-back value so the datapath can update Rn in the exit microstate.

---
 rtl/ldm_stm_sequencer_pkg.sv | 21 ++
 rtl/ldm_stm_sequencer_reglist_priority_encoder.sv | 22 ++
 rtl/ldm_stm_sequencer.sv | 133 +++++++++++++
 tb/tb_ldm_stm_sequencer.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/ldm_stm_sequencer_pkg.sv
// Shared types and constants for the LDM/STM register-list sequencer.
package ldm_stm_sequencer_pkg;

    localparam int unsigned LIST_W     = 16;
    localparam int unsigned IDX_W      = 4;
    localparam int unsigned CNT_W      = 5;
    localparam int unsigned WORD_BYTES = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Addressing modes encoded as {up, pre}
    localparam logic [1:0] MODE_IA = 2'b10;
    localparam logic [1:0] MODE_IB = 2'b11;
    localparam logic [1:0] MODE_DA = 2'b00;
    localparam logic [1:0] MODE_DB = 2'b01;

endpackage

// File: rtl/ldm_stm_sequencer_reglist_priority_encoder.sv
// 16->4 lowest-set-bit encoder over the remaining register mask.
module reglist_priority_encoder
    import ldm_stm_sequencer_pkg::*;
(
    input  logic [LIST_W-1:0] mask,
    output logic [IDX_W-1:0]  idx,
    output logic              valid
);

    // Scan from the top so the lowest set bit is the last one written
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = LIST_W - 1; i >= 0; i--) begin
            if (mask[i]) begin
                idx   = IDX_W'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ldm_stm_sequencer.sv
// Register-list sequencer for LDM/STM block transfers: walks the list in
// ascending register order, producing per-step register index and address,
// plus the base write-back value.
module ldm_stm_sequencer #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned WORD_BYTES = ldm_stm_sequencer_pkg::WORD_BYTES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [15:0]       reg_list,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              up,
    input  logic              pre,
    input  logic              step,
    output logic              busy,
    output logic              done,
    output logic [3:0]        reg_idx,
    output logic [ADDR_W-1:0] xfer_addr,
    output logic [ADDR_W-1:0] wb_addr,
    output logic [4:0]        count,
    output logic              pc_in_list
);

    import ldm_stm_sequencer_pkg::*;

    localparam logic [ADDR_W-1:0] STEP_BYTES = ADDR_W'(WORD_BYTES);

    state_e             state_q, state_d;
    logic [LIST_W-1:0]  mask_q, mask_d;
    logic [ADDR_W-1:0]  xfer_d, wb_d;
    logic [CNT_W-1:0]   count_d;
    logic               pc_d, busy_d, done_d;

    logic [IDX_W-1:0]   enc_idx;
    logic               enc_valid;
    logic [LIST_W-1:0]  mask_next;
    logic               advance;

    logic [1:0]         pc_l1 [8];
    logic [2:0]         pc_l2 [4];
    logic [3:0]         pc_l3 [2];
    logic [CNT_W-1:0]   n_regs;
    logic [ADDR_W-1:0]  span;

    reglist_priority_encoder u_enc (
        .mask  (mask_q),
        .idx   (enc_idx),
        .valid (enc_valid)
    );

    assign reg_idx = enc_idx;

    // Popcount of the incoming list as a balanced adder tree
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            pc_l1[i] = 2'(reg_list[2*i]) + 2'(reg_list[2*i+1]);
        end
        for (int i = 0; i < 4; i++) begin
            pc_l2[i] = 3'(pc_l1[2*i]) + 3'(pc_l1[2*i+1]);
        end
        for (int i = 0; i < 2; i++) begin
            pc_l3[i] = 4'(pc_l2[2*i]) + 4'(pc_l2[2*i+1]);
        end
        n_regs = CNT_W'(pc_l3[0]) + CNT_W'(pc_l3[1]);
        span   = ADDR_W'(n_regs) * STEP_BYTES;
    end

    // Remaining mask with the current (lowest) register retired
    assign mask_next = mask_q & (mask_q - LIST_W'(1));
    assign advance   = (state_q == ST_RUN) && step && enc_valid;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            mask_q     <= '0;
            xfer_addr  <= '0;
            wb_addr    <= '0;
            count      <= '0;
            pc_in_list <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state_q    <= state_d;
            mask_q     <= mask_d;
            xfer_addr  <= xfer_d;
            wb_addr    <= wb_d;
            count      <= count_d;
            pc_in_list <= pc_d;
            busy       <= busy_d;
            done       <= done_d;
        end
    end

    // Next-state logic; start wins over step and aborts a running list
    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = (n_regs == '0) ? ST_DONE : ST_RUN;
        end else if (advance && (mask_next == '0)) begin
            state_d = ST_DONE;
        end
    end

    // Next values of the registered outputs and the remaining mask
    always_comb begin
        mask_d  = mask_q;
        xfer_d  = xfer_addr;
        wb_d    = wb_addr;
        count_d = count;
        pc_d    = pc_in_list;
        busy_d  = (state_d == ST_RUN);
        done_d  = (state_d == ST_DONE);
        if (start) begin
            mask_d  = reg_list;
            count_d = n_regs;
            pc_d    = reg_list[15];
            wb_d    = up ? (base_addr + span) : (base_addr - span);
            unique case ({up, pre})
                MODE_IA: xfer_d = base_addr;
                MODE_IB: xfer_d = base_addr + STEP_BYTES;
                MODE_DA: xfer_d = base_addr - span + STEP_BYTES;
                MODE_DB: xfer_d = base_addr - span;
                default: xfer_d = base_addr;
            endcase
        end else if (advance) begin
            mask_d = mask_next;
            xfer_d = xfer_addr + STEP_BYTES;
        end
    end

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Directed, table-driven bench for ldm_stm_sequencer.
module tb_ldm_stm_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] reg_list;
    logic [31:0] base_addr;
    logic        up;
    logic        pre;
    logic        step;
    logic        busy;
    logic        done;
    logic [3:0]  reg_idx;
    logic [31:0] xfer_addr;
    logic [31:0] wb_addr;
    logic [4:0]  count;
    logic        pc_in_list;

    int n_cmp = 0;
    int n_bad = 0;

    ldm_stm_sequencer #(.ADDR_W(32), .WORD_BYTES(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .reg_list   (reg_list),
        .base_addr  (base_addr),
        .up         (up),
        .pre        (pre),
        .step       (step),
        .busy       (busy),
        .done       (done),
        .reg_idx    (reg_idx),
        .xfer_addr  (xfer_addr),
        .wb_addr    (wb_addr),
        .count      (count),
        .pc_in_list (pc_in_list)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        up;
        logic        pre;
        logic [31:0] base;
        logic [15:0] list;
        logic [31:0] first;
        logic [31:0] wb;
        logic [4:0]  cnt;
        logic        pc;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic u, input logic p, input logic [31:0] b, input logic [15:0] l);
        start     = 1'b1;
        up        = u;
        pre       = p;
        base_addr = b;
        reg_list  = l;
        tick();
        start     = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".busy"},  32'(busy), 32'd0);
        chk({tag, ".done"},  32'(done), 32'd0);
        chk({tag, ".idx"},   32'(reg_idx), 32'd0);
        chk({tag, ".addr"},  xfer_addr, 32'd0);
        chk({tag, ".wb"},    wb_addr, 32'd0);
        chk({tag, ".count"}, 32'(count), 32'd0);
        chk({tag, ".pc"},    32'(pc_in_list), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] exp_addr;
        logic [15:0] lst;

        //                 up    pre   base          list      first         wb            cnt    pc
        vecs[0] = '{1'b1, 1'b0, 32'h0000_1000, 16'h0013, 32'h0000_1000, 32'h0000_100C, 5'd3, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 32'h0000_1000, 16'h0013, 32'h0000_0FF4, 32'h0000_0FF4, 5'd3, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 32'h0000_1000, 16'h0013, 32'h0000_1004, 32'h0000_100C, 5'd3, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 32'h0000_1000, 16'h0013, 32'h0000_0FF8, 32'h0000_0FF4, 5'd3, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 32'hFFFF_FFF8, 16'h0007, 32'hFFFF_FFF8, 32'h0000_0004, 5'd3, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 32'h0000_2000, 16'h8001, 32'h0000_1FF8, 32'h0000_1FF8, 5'd2, 1'b1};
        vecs[6] = '{1'b1, 1'b0, 32'h0000_3000, 16'h0000, 32'h0000_3000, 32'h0000_3000, 5'd0, 1'b0};
        vecs[7] = '{1'b0, 1'b0, 32'h0000_0004, 16'h0003, 32'h0000_0000, 32'hFFFF_FFFC, 5'd2, 1'b0};

        rst = 1'b0; start = 1'b0; reg_list = '0; base_addr = '0;
        up = 1'b0; pre = 1'b0; step = 1'b0;
        #12;
        chk_all_zero("reset");
        @(negedge clk);
        rst = 1'b1;
        tick();

        // Idle ignores step
        step = 1'b1;
        tick();
        step = 1'b0;
        chk_all_zero("idle_step");

        // Table-driven transfers with step held high
        for (int v = 0; v < 8; v++) begin
            do_start(vecs[v].up, vecs[v].pre, vecs[v].base, vecs[v].list);
            chk($sformatf("v%0d.count", v), 32'(count), 32'(vecs[v].cnt));
            chk($sformatf("v%0d.wb", v), wb_addr, vecs[v].wb);
            chk($sformatf("v%0d.pc", v), 32'(pc_in_list), 32'(vecs[v].pc));
            if (vecs[v].cnt != 5'd0) begin
                exp_addr = vecs[v].first;
                lst = vecs[v].list;
                for (int r = 0; r < 16; r++) begin
                    if (lst[r]) begin
                        chk($sformatf("v%0d.busy", v), 32'(busy), 32'd1);
                        chk($sformatf("v%0d.done_lo", v), 32'(done), 32'd0);
                        chk($sformatf("v%0d.idx", v), 32'(reg_idx), 32'(r));
                        chk($sformatf("v%0d.addr", v), xfer_addr, exp_addr);
                        step = 1'b1;
                        tick();
                        exp_addr = exp_addr + 32'd4;
                    end
                end
                step = 1'b0;
            end
            chk($sformatf("v%0d.done", v), 32'(done), 32'd1);
            chk($sformatf("v%0d.busy_end", v), 32'(busy), 32'd0);
            chk($sformatf("v%0d.wb_end", v), wb_addr, vecs[v].wb);
            // DONE holds and ignores step
            step = 1'b1;
            tick();
            step = 1'b0;
            chk($sformatf("v%0d.done_hold", v), 32'(done), 32'd1);
        end

        // Full list with step toggling: outputs hold on step=0
        do_start(1'b1, 1'b0, 32'h0000_8000, 16'hFFFF);
        chk("full.count", 32'(count), 32'd16);
        chk("full.pc", 32'(pc_in_list), 32'd1);
        chk("full.wb", wb_addr, 32'h0000_8040);
        for (int k = 0; k < 16; k++) begin
            step = 1'b0;
            tick();
            chk($sformatf("full.hold_idx%0d", k), 32'(reg_idx), 32'(k));
            chk($sformatf("full.hold_addr%0d", k), xfer_addr, 32'h0000_8000 + 32'(4 * k));
            chk($sformatf("full.busy%0d", k), 32'(busy), 32'd1);
            step = 1'b1;
            tick();
        end
        step = 1'b0;
        chk("full.done", 32'(done), 32'd1);
        chk("full.busy_end", 32'(busy), 32'd0);

        // start + step together mid-run: reload wins, step ignored
        do_start(1'b1, 1'b0, 32'h0000_0100, 16'h00F0);
        step = 1'b1;
        tick();
        chk("abort.pre_idx", 32'(reg_idx), 32'd5);
        step = 1'b1;
        do_start(1'b0, 1'b1, 32'h0000_0200, 16'h0300);
        step = 1'b0;
        chk("abort.idx", 32'(reg_idx), 32'd8);
        chk("abort.addr", xfer_addr, 32'h0000_01F8);
        chk("abort.count", 32'(count), 32'd2);
        chk("abort.wb", wb_addr, 32'h0000_01F8);
        chk("abort.busy", 32'(busy), 32'd1);

        // Asynchronous reset mid-run clears everything without a clock edge
        do_start(1'b1, 1'b0, 32'h0000_0500, 16'h80FF);
        step = 1'b1;
        tick();
        step = 1'b0;
        chk("rstmid.busy_pre", 32'(busy), 32'd1);
        rst = 1'b0;
        #2;
        chk_all_zero("rstmid");
        @(negedge clk);
        rst = 1'b1;
        tick();
        chk_all_zero("rstmid_after");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
